// File: rtl/photon_state_serializer.sv
// photon_state_serializer
// Captures the 8x8-byte Photon permutation state in one parallel transfer and
// streams it out one byte per beat over a valid/ready interface. One state is
// buffered; a new state may load on the same edge that the last byte leaves,
// so back-to-back states stream without a bubble.

module photon_state_serializer #(
    parameter int COLUMN_MAJOR = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_in_valid,
    output logic       io_in_ready,
    input  logic [7:0] io_state_0_0,
    input  logic [7:0] io_state_0_1,
    input  logic [7:0] io_state_0_2,
    input  logic [7:0] io_state_0_3,
    input  logic [7:0] io_state_0_4,
    input  logic [7:0] io_state_0_5,
    input  logic [7:0] io_state_0_6,
    input  logic [7:0] io_state_0_7,
    input  logic [7:0] io_state_1_0,
    input  logic [7:0] io_state_1_1,
    input  logic [7:0] io_state_1_2,
    input  logic [7:0] io_state_1_3,
    input  logic [7:0] io_state_1_4,
    input  logic [7:0] io_state_1_5,
    input  logic [7:0] io_state_1_6,
    input  logic [7:0] io_state_1_7,
    input  logic [7:0] io_state_2_0,
    input  logic [7:0] io_state_2_1,
    input  logic [7:0] io_state_2_2,
    input  logic [7:0] io_state_2_3,
    input  logic [7:0] io_state_2_4,
    input  logic [7:0] io_state_2_5,
    input  logic [7:0] io_state_2_6,
    input  logic [7:0] io_state_2_7,
    input  logic [7:0] io_state_3_0,
    input  logic [7:0] io_state_3_1,
    input  logic [7:0] io_state_3_2,
    input  logic [7:0] io_state_3_3,
    input  logic [7:0] io_state_3_4,
    input  logic [7:0] io_state_3_5,
    input  logic [7:0] io_state_3_6,
    input  logic [7:0] io_state_3_7,
    input  logic [7:0] io_state_4_0,
    input  logic [7:0] io_state_4_1,
    input  logic [7:0] io_state_4_2,
    input  logic [7:0] io_state_4_3,
    input  logic [7:0] io_state_4_4,
    input  logic [7:0] io_state_4_5,
    input  logic [7:0] io_state_4_6,
    input  logic [7:0] io_state_4_7,
    input  logic [7:0] io_state_5_0,
    input  logic [7:0] io_state_5_1,
    input  logic [7:0] io_state_5_2,
    input  logic [7:0] io_state_5_3,
    input  logic [7:0] io_state_5_4,
    input  logic [7:0] io_state_5_5,
    input  logic [7:0] io_state_5_6,
    input  logic [7:0] io_state_5_7,
    input  logic [7:0] io_state_6_0,
    input  logic [7:0] io_state_6_1,
    input  logic [7:0] io_state_6_2,
    input  logic [7:0] io_state_6_3,
    input  logic [7:0] io_state_6_4,
    input  logic [7:0] io_state_6_5,
    input  logic [7:0] io_state_6_6,
    input  logic [7:0] io_state_6_7,
    input  logic [7:0] io_state_7_0,
    input  logic [7:0] io_state_7_1,
    input  logic [7:0] io_state_7_2,
    input  logic [7:0] io_state_7_3,
    input  logic [7:0] io_state_7_4,
    input  logic [7:0] io_state_7_5,
    input  logic [7:0] io_state_7_6,
    input  logic [7:0] io_state_7_7,
    output logic       io_out_valid,
    input  logic       io_out_ready,
    output logic [7:0] io_out_bits,
    output logic [5:0] io_out_index,
    output logic       io_out_last
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Byte k of the buffer holds state[r][c] with k = 8*r + c.
    logic [7:0] in_byte_s [64];
    logic [7:0] buf_q     [64];
    logic [7:0] buf_d     [64];
    state_e     state_q;
    state_e     state_d;
    logic [5:0] idx_q;
    logic [5:0] idx_d;
    logic       in_ready_s;
    logic       in_fire_s;
    logic       out_valid_s;
    logic       out_fire_s;
    logic [5:0] rd_addr_s;

    assign in_byte_s[6'd0]  = io_state_0_0;
    assign in_byte_s[6'd1]  = io_state_0_1;
    assign in_byte_s[6'd2]  = io_state_0_2;
    assign in_byte_s[6'd3]  = io_state_0_3;
    assign in_byte_s[6'd4]  = io_state_0_4;
    assign in_byte_s[6'd5]  = io_state_0_5;
    assign in_byte_s[6'd6]  = io_state_0_6;
    assign in_byte_s[6'd7]  = io_state_0_7;
    assign in_byte_s[6'd8]  = io_state_1_0;
    assign in_byte_s[6'd9]  = io_state_1_1;
    assign in_byte_s[6'd10] = io_state_1_2;
    assign in_byte_s[6'd11] = io_state_1_3;
    assign in_byte_s[6'd12] = io_state_1_4;
    assign in_byte_s[6'd13] = io_state_1_5;
    assign in_byte_s[6'd14] = io_state_1_6;
    assign in_byte_s[6'd15] = io_state_1_7;
    assign in_byte_s[6'd16] = io_state_2_0;
    assign in_byte_s[6'd17] = io_state_2_1;
    assign in_byte_s[6'd18] = io_state_2_2;
    assign in_byte_s[6'd19] = io_state_2_3;
    assign in_byte_s[6'd20] = io_state_2_4;
    assign in_byte_s[6'd21] = io_state_2_5;
    assign in_byte_s[6'd22] = io_state_2_6;
    assign in_byte_s[6'd23] = io_state_2_7;
    assign in_byte_s[6'd24] = io_state_3_0;
    assign in_byte_s[6'd25] = io_state_3_1;
    assign in_byte_s[6'd26] = io_state_3_2;
    assign in_byte_s[6'd27] = io_state_3_3;
    assign in_byte_s[6'd28] = io_state_3_4;
    assign in_byte_s[6'd29] = io_state_3_5;
    assign in_byte_s[6'd30] = io_state_3_6;
    assign in_byte_s[6'd31] = io_state_3_7;
    assign in_byte_s[6'd32] = io_state_4_0;
    assign in_byte_s[6'd33] = io_state_4_1;
    assign in_byte_s[6'd34] = io_state_4_2;
    assign in_byte_s[6'd35] = io_state_4_3;
    assign in_byte_s[6'd36] = io_state_4_4;
    assign in_byte_s[6'd37] = io_state_4_5;
    assign in_byte_s[6'd38] = io_state_4_6;
    assign in_byte_s[6'd39] = io_state_4_7;
    assign in_byte_s[6'd40] = io_state_5_0;
    assign in_byte_s[6'd41] = io_state_5_1;
    assign in_byte_s[6'd42] = io_state_5_2;
    assign in_byte_s[6'd43] = io_state_5_3;
    assign in_byte_s[6'd44] = io_state_5_4;
    assign in_byte_s[6'd45] = io_state_5_5;
    assign in_byte_s[6'd46] = io_state_5_6;
    assign in_byte_s[6'd47] = io_state_5_7;
    assign in_byte_s[6'd48] = io_state_6_0;
    assign in_byte_s[6'd49] = io_state_6_1;
    assign in_byte_s[6'd50] = io_state_6_2;
    assign in_byte_s[6'd51] = io_state_6_3;
    assign in_byte_s[6'd52] = io_state_6_4;
    assign in_byte_s[6'd53] = io_state_6_5;
    assign in_byte_s[6'd54] = io_state_6_6;
    assign in_byte_s[6'd55] = io_state_6_7;
    assign in_byte_s[6'd56] = io_state_7_0;
    assign in_byte_s[6'd57] = io_state_7_1;
    assign in_byte_s[6'd58] = io_state_7_2;
    assign in_byte_s[6'd59] = io_state_7_3;
    assign in_byte_s[6'd60] = io_state_7_4;
    assign in_byte_s[6'd61] = io_state_7_5;
    assign in_byte_s[6'd62] = io_state_7_6;
    assign in_byte_s[6'd63] = io_state_7_7;

    // Input readiness: idle, or on the final beat as it is being accepted,
    // which is what lets a new state follow the old one without a gap.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_s = 1'b1;
            ST_SEND: in_ready_s = (idx_q == 6'd63) && io_out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign in_fire_s   = io_in_valid && in_ready_s;
    assign out_valid_s = (state_q == ST_SEND);
    assign out_fire_s  = out_valid_s && io_out_ready;

    // Next-state logic: a load takes priority (it also covers the final beat
    // leaving); otherwise an accepted beat advances or ends the stream.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        if (in_fire_s) begin
            for (int k = 0; k < 64; k++) begin
                buf_d[k] = in_byte_s[k];
            end
            idx_d   = 6'd0;
            state_d = ST_SEND;
        end else if (out_fire_s) begin
            if (idx_q == 6'd63) begin
                state_d = ST_IDLE;
            end else begin
                idx_d = idx_q + 6'd1;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, beat counter and buffer registers; reset discards any stream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 6'd0;
            for (int k = 0; k < 64; k++) begin
                buf_q[k] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int k = 0; k < 64; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

    // Read address: row-major walks the buffer linearly, column-major swaps
    // the row and column fields of the beat counter.
    always_comb begin
        rd_addr_s = idx_q;
        if (COLUMN_MAJOR != 0) begin
            rd_addr_s = {idx_q[2:0], idx_q[5:3]};
        end else begin
            rd_addr_s = idx_q;
        end
    end

    assign io_in_ready  = in_ready_s;
    assign io_out_valid = out_valid_s;
    assign io_out_index = idx_q;
    assign io_out_last  = out_valid_s && (idx_q == 6'd63);
    assign io_out_bits  = buf_q[rd_addr_s];

endmodule

// File: doc/photon_state_serializer.md
# photon_state_serializer

Output-side companion to the `Photon` permutation core. The block captures the full 8x8-byte permutation state in one parallel transfer and streams it out one byte per beat over a valid/ready interface. Downstream tag/ciphertext logic consumes that stream. It buffers exactly one state and supports gapless back-to-back states: a new state loads on the same edge that the previous state's last byte leaves.

## Interface
Parameters:
- `COLUMN_MAJOR`, default 0: 0 = emit row-major (r0c0, r0c1, …, r7c7); 1 = emit column-major (r0c0, r1c0, …, r7c7).

Ports:
- `clock`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `io_in_valid`  input  1  parallel state offered.
- `io_in_ready`  output  1  block can accept a state this cycle.
- `io_state_<r>_<c>`  input  8  state byte at row r, column c, r,c ∈ 0..7 (64 ports).
- `io_out_valid`  output  1  `io_out_bits` holds a valid byte.
- `io_out_ready`  input  1  downstream accepts the byte.
- `io_out_bits`  output  8  current state byte.
- `io_out_index`  output  6  beat number of the current byte, 0..63.
- `io_out_last`  output  1  high when `io_out_index` = 63 and `io_out_valid` = 1.

## Operation
- Storage:
  - 64x8-bit buffer `buf[r][c]`.
  - 6-bit beat counter `idx`.
  - FSM with states IDLE and SEND.
- Input handshake:
  - In = `io_in_valid && io_in_ready`.
  - `io_in_ready` = (state == IDLE) || (state == SEND && idx == 63 && `io_out_ready`).
  - On In, all 64 `io_state_*` bytes load into `buf`, `idx` clears to 0, and the next state is SEND.
- Output handshake:
  - Out = `io_out_valid && io_out_ready`.
  - `io_out_valid` = (state == SEND).
  - `io_out_index` = `idx`.
  - `io_out_last` = `io_out_valid` && `idx` == 63.
- Byte selection:
  - Row-major (`COLUMN_MAJOR` = 0): `io_out_bits` = `buf[idx[5:3]][idx[2:0]]`.
  - Column-major (`COLUMN_MAJOR` = 1): `io_out_bits` = `buf[idx[2:0]][idx[5:3]]`.
  - `io_out_bits` is a combinational mux of registered data.
- FSM transitions:
  - IDLE → SEND on In.
  - SEND, Out with `idx` < 63: `idx` increments, state stays SEND.
  - SEND, Out with `idx` == 63 and no In: state → IDLE. `idx` and `buf` hold their values.
  - SEND, Out with `idx` == 63 and In on the same edge: new state loads, `idx` → 0, state stays SEND.
  - SEND without Out: everything holds. `io_out_bits` and `io_out_index` stay stable while stalled.
- Input changes:
  - `io_state_*` changes outside an In edge have no effect.
  - `io_in_valid` asserted while `io_in_ready` = 0 is ignored; no capture occurs.
- Counter arithmetic: `idx` is 6-bit and never wraps by increment. Reaching 0 after 63 happens only through a load.

## Timing
- Reset values (asynchronous, immediate on `reset` high):
  - state IDLE, `idx` 0, `buf` all 0x00.
  - Outputs: `io_in_ready` 1, `io_out_valid` 0, `io_out_last` 0, `io_out_index` 0, `io_out_bits` 0x00.
- Reset mid-stream: the in-flight state is discarded. After reset deasserts, the first rising edge behaves as IDLE.
- Latency: In on edge N → byte 0 valid during cycle N+1. With `io_out_ready` held high, byte 63 is valid during cycle N+64.
- Throughput: with `io_out_ready` constantly high and a state offered at every last beat, output is 64 bytes per 64 cycles with no bubble.
- Gap: if no state is offered at the last beat, `io_out_valid` is 0 for at least one cycle.
- No combinational path from `io_in_valid` or `io_state_*` to any output.
- `io_in_ready` depends combinationally on `io_out_ready`.

## Test plan
- Row-major basic: load `io_state_r_c` = 8r+c, hold `io_out_ready` = 1.
  - Required: bytes 0x00..0x3F in order on consecutive cycles, `io_out_index` matching.
  - `io_out_last` high only on 0x3F, then `io_out_valid` 0 and `io_in_ready` 1.
- Column-major (`COLUMN_MAJOR` = 1), same stimulus.
  - Required sequence: 0x00, 0x08, 0x10, …, 0x38, 0x01, 0x09, …, 0x3F.
- Backpressure: drop `io_out_ready` for 5 cycles at `idx` = 10.
  - Required: `io_out_bits` = 0x0A and `io_out_index` = 10 held stable throughout the stall; no byte skipped or duplicated.
  - The full stream takes 69 cycles.
- Back-to-back: offer a second state (all bytes 0xA5) with `io_in_valid` held high from the start.
  - Required: no capture until the last beat, then the beat after 0x3F is 0xA5 with `io_out_valid` continuously high.
- Busy ignore: change `io_state_*` to 0xFF mid-stream with `io_in_valid` = 1 at `idx` = 30.
  - Required: remaining bytes still 0x1F..0x3F.
- Reset mid-operation: assert `reset` at `idx` = 20.
  - Required: `io_out_valid` drops immediately, `io_in_ready` = 1, `io_out_bits` = 0x00.
  - A fresh load then streams from index 0.
